muldiv_sequencer: RTL and testbench

- Multi-cycle controller and iterative datapath for the RV32M multiply/divide instructions.
- Sits beside the single-cycle ALU in the EX stage.
- The pipeline issues an M-type operation. The block then asserts BUSY so the hazard unit stalls IF/ID/EX, runs a 32-step shift-add or restoring-divide sequence, and returns a 32-bit result with a one-cycle VALID strobe.

---
 rtl/muldiv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide sequencer (optional MULDIV_EARLY_OUT_EN early-out)
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            KILL,
    output logic            BUSY,
    output logic            VALID,
    output logic [XLEN-1:0] RESULT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ADJ  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_funct3;
    logic [2*XLEN-1:0]   r_acc;      // mul: {hi, multiplier}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]     r_opb;      // mul: multiplicand magnitude; div: divisor magnitude
    logic                r_neg_q;    // product / quotient needs negation
    logic                r_neg_r;    // remainder needs negation (sign of dividend)
    logic                r_dz;       // divide by zero
    logic [XLEN-1:0]     r_result;

    // Operand decode at acceptance
    logic                w_accept;
    logic                w_is_div;
    logic                w_s1;
    logic                w_s2;
    logic                w_neg1;
    logic                w_neg2;
    logic [XLEN-1:0]     w_mag1;
    logic [XLEN-1:0]     w_mag2;
    logic                w_dz;
    logic                w_last;
    logic                w_early;
    logic [XLEN-1:0]     w_early_res;

    assign w_accept = (r_state == S_IDLE) && START && !KILL;
    assign w_is_div = FUNCT3[2];
    assign w_s1     = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010) ||
                      (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
    assign w_s2     = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
    assign w_neg1   = w_s1 && DATA1[XLEN-1];
    assign w_neg2   = w_s2 && DATA2[XLEN-1];
    assign w_mag1   = w_neg1 ? (~DATA1 + 1'b1) : DATA1;
    assign w_mag2   = w_neg2 ? (~DATA2 + 1'b1) : DATA2;
    assign w_dz     = (DATA2 == '0);
    assign w_last   = (r_cnt == CNT_W'(XLEN-1));

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early     = w_is_div ? w_dz : ((DATA1 == '0) || w_dz);
    assign w_early_res = w_is_div ? (FUNCT3[1] ? DATA1 : '1) : '0;
`else
    assign w_early     = 1'b0;
    assign w_early_res = '0;
`endif

    // One shift-add / restoring-divide step
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_shift;
    logic [XLEN:0]       w_trial;
    logic [2*XLEN-1:0]   w_div_next;

    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_shift    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_trial    = w_shift - {1'b0, r_opb};
    assign w_div_next = w_trial[XLEN] ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                      : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    // Sign fix-up and result selection
    logic [2*XLEN-1:0]   w_prod_fin;
    logic [XLEN-1:0]     w_quo_fin;
    logic [XLEN-1:0]     w_rem_fin;
    logic [XLEN-1:0]     w_sel;

    assign w_prod_fin = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo_fin  = r_dz ? '1 : (r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0]);
    assign w_rem_fin  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

    // Pick the architectural result word for the latched opcode
    always_comb begin
        w_sel = '0;
        case (r_funct3)
            3'b000:                 w_sel = w_prod_fin[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_sel = w_prod_fin[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_sel = w_quo_fin;
            default:                w_sel = w_rem_fin;
        endcase
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next = r_state;
        BUSY   = (r_state != S_IDLE);
        VALID  = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_early ? S_DONE : S_CALC;
            S_CALC: begin
                if (KILL)        w_next = S_IDLE;
                else if (w_last) w_next = S_ADJ;
            end
            S_ADJ:  w_next = KILL ? S_IDLE : S_DONE;
            S_DONE: begin
                VALID  = !KILL;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_funct3 <= FUNCT3;
                    r_cnt    <= '0;
                    r_neg_q  <= w_neg1 ^ w_neg2;
                    r_neg_r  <= w_neg1;
                    r_dz     <= w_dz;
                    r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
                    r_opb    <= w_is_div ? w_mag2 : w_mag1;
                    if (w_early) r_result <= w_early_res;
                end
                S_CALC: if (!KILL) begin
                    r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
                    if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
                end
                S_ADJ: if (!KILL) r_result <= w_sel;
                default: ;
            endcase
        end
    end

    assign RESULT = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic [2:0]  FUNCT3;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic        KILL;
    logic        BUSY;
    logic        VALID;
    logic [31:0] RESULT;

    int total = 0;
    int bad   = 0;

    localparam int LAT_FULL = 34;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_EARLY = 1;
`else
    localparam int LAT_EARLY = 34;
`endif

    muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
        .FUNCT3  (FUNCT3),
        .DATA1   (DATA1),
        .DATA2   (DATA2),
        .KILL    (KILL),
        .BUSY    (BUSY),
        .VALID   (VALID),
        .RESULT  (RESULT)
    );

    always #5 CLK = ~CLK;

    // Issue one op from an IDLE negedge; lat counts negedges after acceptance edge up to VALID (0 = timeout)
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        FUNCT3 = f; DATA1 = a; DATA2 = b; START = 1'b1;
        @(posedge CLK);
        lat = 0;
        res = 32'hDEAD_BEEF;
        for (int n = 1; n <= 100; n++) begin
            @(negedge CLK);
            START = 1'b0; FUNCT3 = ~f; DATA1 = ~a; DATA2 = ~b;
            if (VALID === 1'b1) begin
                lat = n;
                res = RESULT;
                break;
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        int          l;
        RESET_N = 1'b0; START = 1'b1; KILL = 1'b0; FUNCT3 = 3'b000; DATA1 = 32'd7; DATA2 = 32'd6;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        total++; if (BUSY !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        total++; if (VALID !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%b exp=0", VALID); end
        total++; if (RESULT !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=00000000", RESULT); end
        RESET_N = 1'b1; START = 1'b0;
        @(negedge CLK);
        do_op(3'b000, 32'd7, 32'd6, r, l);
        total++; if (r !== 32'h0000002A) begin bad++; $display("FAIL mul_7x6 got=%h exp=0000002a", r); end
        total++; if (l !== LAT_FULL)     begin bad++; $display("FAIL mul_latency got=%0d exp=%0d", l, LAT_FULL); end
    endtask

    task automatic test_multiply();
        logic [31:0] r;
        int          l;
        do_op(3'b001, 32'hFFFFFFFE, 32'h00000003, r, l);
        total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL mulh_neg2x3 got=%h exp=ffffffff", r); end
        do_op(3'b000, 32'hFFFFFFFE, 32'h00000003, r, l);
        total++; if (r !== 32'hFFFFFFFA) begin bad++; $display("FAIL mul_neg2x3 got=%h exp=fffffffa", r); end
        do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, l);
        total++; if (r !== 32'hFFFFFFFE) begin bad++; $display("FAIL mulhu_max got=%h exp=fffffffe", r); end
        do_op(3'b010, 32'hFFFFFFFF, 32'h00000002, r, l);
        total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL mulhsu_neg1x2 got=%h exp=ffffffff", r); end
        do_op(3'b001, 32'h80000000, 32'h80000000, r, l);
        total++; if (r !== 32'h40000000) begin bad++; $display("FAIL mulh_min_sq got=%h exp=40000000", r); end
        do_op(3'b000, 32'h00000000, 32'h00000005, r, l);
        total++; if (r !== 32'h00000000) begin bad++; $display("FAIL mul_zero got=%h exp=00000000", r); end
        total++; if (l !== LAT_EARLY)    begin bad++; $display("FAIL mul_zero_latency got=%0d exp=%0d", l, LAT_EARLY); end
    endtask

    task automatic test_divide();
        logic [31:0] r;
        int          l;
        do_op(3'b100, 32'hFFFFFFF9, 32'd2, r, l);
        total++; if (r !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_m7_2 got=%h exp=fffffffd", r); end
        do_op(3'b110, 32'hFFFFFFF9, 32'd2, r, l);
        total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL rem_m7_2 got=%h exp=ffffffff", r); end
        do_op(3'b101, 32'd100, 32'd7, r, l);
        total++; if (r !== 32'd14)       begin bad++; $display("FAIL divu_100_7 got=%h exp=0000000e", r); end
        do_op(3'b111, 32'd100, 32'd7, r, l);
        total++; if (r !== 32'd2)        begin bad++; $display("FAIL remu_100_7 got=%h exp=00000002", r); end
        do_op(3'b110, 32'd7, 32'hFFFFFFFE, r, l);
        total++; if (r !== 32'd1)        begin bad++; $display("FAIL rem_7_m2 got=%h exp=00000001", r); end
    endtask

    task automatic test_corner();
        logic [31:0] r;
        int          l;
        do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, r, l);
        total++; if (r !== 32'h80000000) begin bad++; $display("FAIL div_overflow got=%h exp=80000000", r); end
        do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, r, l);
        total++; if (r !== 32'h00000000) begin bad++; $display("FAIL rem_overflow got=%h exp=00000000", r); end
        do_op(3'b101, 32'd5, 32'd0, r, l);
        total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu_by0 got=%h exp=ffffffff", r); end
        total++; if (l !== LAT_EARLY)    begin bad++; $display("FAIL divu_by0_latency got=%0d exp=%0d", l, LAT_EARLY); end
        do_op(3'b110, 32'd5, 32'd0, r, l);
        total++; if (r !== 32'd5)        begin bad++; $display("FAIL rem_by0 got=%h exp=00000005", r); end
        do_op(3'b100, 32'hFFFFFFFB, 32'd0, r, l);
        total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg_by0 got=%h exp=ffffffff", r); end
        do_op(3'b110, 32'hFFFFFFFB, 32'd0, r, l);
        total++; if (r !== 32'hFFFFFFFB) begin bad++; $display("FAIL rem_neg_by0 got=%h exp=fffffffb", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [31:0] first_res;
        int          l;
        int          nvalid;
        int          first_at;
        nvalid = 0; first_at = 0; first_res = 32'h0;
        FUNCT3 = 3'b000; DATA1 = 32'd3; DATA2 = 32'd5; START = 1'b1;
        @(posedge CLK);
        for (int n = 1; n <= 60; n++) begin
            @(negedge CLK);
            START = 1'b0;
            if (n == 5) begin
                START = 1'b1; FUNCT3 = 3'b101; DATA1 = 32'd99; DATA2 = 32'd9;
            end
            if (VALID === 1'b1) begin
                nvalid++;
                if (first_at == 0) begin
                    first_at  = n;
                    first_res = RESULT;
                    START = 1'b1; FUNCT3 = 3'b101; DATA1 = 32'd20; DATA2 = 32'd4;
                end
            end
        end
        total++; if (nvalid !== 1)          begin bad++; $display("FAIL b2b_valid_count got=%0d exp=1", nvalid); end
        total++; if (first_at !== LAT_FULL) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", first_at, LAT_FULL); end
        total++; if (first_res !== 32'd15)  begin bad++; $display("FAIL b2b_result got=%h exp=0000000f", first_res); end
        total++; if (BUSY !== 1'b0)         begin bad++; $display("FAIL b2b_idle_busy got=%b exp=0", BUSY); end
        do_op(3'b101, 32'd20, 32'd4, r, l);
        total++; if (r !== 32'd5)           begin bad++; $display("FAIL b2b_next_divu got=%h exp=00000005", r); end
        total++; if (l !== LAT_FULL)        begin bad++; $display("FAIL b2b_next_latency got=%0d exp=%0d", l, LAT_FULL); end
    endtask

    task automatic test_kill();
        logic [31:0] r;
        int          l;
        int          nvalid;
        // KILL together with START in IDLE: not started
        START = 1'b1; KILL = 1'b1; FUNCT3 = 3'b000; DATA1 = 32'd2; DATA2 = 32'd2;
        @(negedge CLK);
        START = 1'b0; KILL = 1'b0;
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL kill_start_busy got=%b exp=0", BUSY); end
        // KILL at iteration 10 of a multiply
        nvalid = 0;
        FUNCT3 = 3'b000; DATA1 = 32'd1000; DATA2 = 32'd1000; START = 1'b1;
        @(posedge CLK);
        for (int n = 1; n <= 50; n++) begin
            @(negedge CLK);
            START = 1'b0;
            if (VALID === 1'b1) nvalid++;
            if (n == 11) KILL = 1'b1;
            if (n == 12) begin
                KILL = 1'b0;
                total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL kill_calc_idle got=%b exp=0", BUSY); end
            end
        end
        total++; if (nvalid !== 0)      begin bad++; $display("FAIL kill_calc_valid got=%0d exp=0", nvalid); end
        total++; if (RESULT !== 32'd5)  begin bad++; $display("FAIL kill_calc_result got=%h exp=00000005", RESULT); end
        do_op(3'b101, 32'd9, 32'd3, r, l);
        total++; if (r !== 32'd3)       begin bad++; $display("FAIL kill_then_divu got=%h exp=00000003", r); end
        // KILL in the DONE cycle suppresses VALID
        FUNCT3 = 3'b000; DATA1 = 32'd2; DATA2 = 32'd2; START = 1'b1;
        @(posedge CLK);
        for (int n = 1; n <= LAT_FULL; n++) begin
            @(negedge CLK);
            START = 1'b0;
        end
        KILL = 1'b1;
        #1;
        total++; if (BUSY !== 1'b1)  begin bad++; $display("FAIL kill_done_busy got=%b exp=1", BUSY); end
        total++; if (VALID !== 1'b0) begin bad++; $display("FAIL kill_done_valid got=%b exp=0", VALID); end
        @(negedge CLK);
        KILL = 1'b0;
        total++; if (BUSY !== 1'b0)  begin bad++; $display("FAIL kill_done_idle got=%b exp=0", BUSY); end
    endtask

    initial begin
        RESET_N = 1'b0; START = 1'b0; KILL = 1'b0;
        FUNCT3 = 3'b000; DATA1 = 32'h0; DATA2 = 32'h0;
        test_reset();
        test_multiply();
        test_divide();
        test_corner();
        test_back_to_back();
        test_kill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
